// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC-8259 bus-side blocks.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    GAP,
    DONE
  } inta_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  localparam int PULSES_8086 = 2;
  localparam int PULSES_8080 = 3;

  localparam int PULSE_IDX_W = 2;
  typedef logic [PULSE_IDX_W-1:0] pulse_idx_t;

  // Index of the final INTA pulse for the selected bus protocol.
  function automatic pulse_idx_t last_pulse_idx(input logic is8080);
    return is8080 ? pulse_idx_t'(PULSES_8080 - 1) : pulse_idx_t'(PULSES_8086 - 1);
  endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchroniser for asynchronous PIC control lines.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side INTA pulse generator for the PIC-8259; captures the vector/CALL bytes.
// Three-pulse 8080 support is compiled in only when INTA_8080_MODE_EN is defined.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_LOW = 2,
  parameter int PULSE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic        cpu_ready,
  input  logic        mode_8080,
  input  logic [7:0]  data_in,
  output logic        inta_n,
  output logic        busy,
  output logic [7:0]  vector,
  output logic [15:0] call_addr,
  output logic        opcode_err,
  output logic        vector_valid,
  input  logic        vector_ack
);

  localparam int CNT_MAX = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic int_s;

  int_sync u_int_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(int_req),
    .sync_o (int_s)
  );

  inta_state_e      state_q, state_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  pulse_idx_t       pulseIdx_q, pulseIdx_d;
  logic [7:0]       vector_q, vector_d;
  logic             lastLow, lastGap, lastPulse;

`ifdef INTA_8080_MODE_EN
  logic             mode8080_q, mode8080_d;
  logic [15:0]      callAddr_q, callAddr_d;
  logic             opcodeErr_q, opcodeErr_d;
`else
  logic             unused_mode;
  assign unused_mode = mode_8080;
`endif

  assign lastLow = (cycleCnt_q == CNT_W'(PULSE_LOW - 1));
  assign lastGap = (cycleCnt_q == CNT_W'(PULSE_GAP - 1));

`ifdef INTA_8080_MODE_EN
  assign lastPulse = (pulseIdx_q == last_pulse_idx(mode8080_q));
`else
  assign lastPulse = (pulseIdx_q == last_pulse_idx(1'b0));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cycleCnt_q  <= '0;
      pulseIdx_q  <= '0;
      vector_q    <= '0;
`ifdef INTA_8080_MODE_EN
      mode8080_q  <= 1'b0;
      callAddr_q  <= '0;
      opcodeErr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cycleCnt_q  <= cycleCnt_d;
      pulseIdx_q  <= pulseIdx_d;
      vector_q    <= vector_d;
`ifdef INTA_8080_MODE_EN
      mode8080_q  <= mode8080_d;
      callAddr_q  <= callAddr_d;
      opcodeErr_q <= opcodeErr_d;
`endif
    end
  end

  // Once started, the pulse train runs to completion regardless of int_s/cpu_ready.
  always_comb begin
    state_d     = state_q;
    cycleCnt_d  = cycleCnt_q;
    pulseIdx_d  = pulseIdx_q;
    vector_d    = vector_q;
`ifdef INTA_8080_MODE_EN
    mode8080_d  = mode8080_q;
    callAddr_d  = callAddr_q;
    opcodeErr_d = opcodeErr_q;
`endif

    case (state_q)
      IDLE: begin
        if (int_s && cpu_ready) begin
          state_d     = LOW;
          cycleCnt_d  = '0;
          pulseIdx_d  = '0;
          vector_d    = '0;
`ifdef INTA_8080_MODE_EN
          mode8080_d  = mode_8080;
          callAddr_d  = '0;
          opcodeErr_d = 1'b0;
`endif
        end
      end

      LOW: begin
        if (lastLow) begin
          cycleCnt_d = '0;
          state_d    = lastPulse ? DONE : GAP;
`ifdef INTA_8080_MODE_EN
          if (mode8080_q) begin
            case (pulseIdx_q)
              2'd0:    opcodeErr_d = (data_in != CALL_OPCODE);
              2'd1:    callAddr_d[7:0] = data_in;
              2'd2:    callAddr_d[15:8] = data_in;
              default: ;
            endcase
          end else if (pulseIdx_q == 2'd1) begin
            vector_d = data_in;
          end
`else
          if (pulseIdx_q == 2'd1) begin
            vector_d = data_in;
          end
`endif
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (lastGap) begin
          cycleCnt_d = '0;
          pulseIdx_d = pulseIdx_q + pulse_idx_t'(1);
          state_d    = LOW;
        end else begin
          cycleCnt_d = cycleCnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (vector_ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign inta_n       = (state_q != LOW);
  assign busy         = (state_q != IDLE);
  assign vector_valid = (state_q == DONE);
  assign vector       = vector_q;

`ifdef INTA_8080_MODE_EN
  assign call_addr  = callAddr_q;
  assign opcode_err = opcodeErr_q && vector_valid;
`else
  assign call_addr  = 16'h0000;
  assign opcode_err = 1'b0;
`endif

endmodule
